// File: rtl/sm4_round_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sm4_round_sched                                              |
// | Description : Iterative SM4 key-expansion / round sequencer sharing one    |
// |               external T/T' unit. Optional key cache: SM4_KEY_CACHE_EN.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sm4_round_sched #(
    parameter int           ROUNDS = 32,
    parameter logic [127:0] FK     = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_input,
    input  logic         isdec,
    input  logic [127:0] datain,
    input  logic [127:0] mkin,
    output logic         in_ready,
    output logic         rf_mode,
    output logic [31:0]  rf_x,
    input  logic [31:0]  rf_t,
    output logic [127:0] dataout,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KEXP = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] c_last_round = 5'(ROUNDS - 1);

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           isdec_q, isdec_d;
    logic [127:0]   x_q, x_d;
    logic [127:0]   k_q, k_d;
    logic [31:0]    rk_q [ROUNDS];

    logic [31:0]    w_ck;
    logic [4:0]     w_rk_idx;
    logic [31:0]    w_rk;
    logic [31:0]    w_new;
    logic           w_hit;

    // CK word i, byte j = ((4i+j)*7) mod 256
    always_comb begin
        w_ck = '0;
        for (int j = 0; j < 4; j++) begin
            w_ck[31-8*j -: 8] = ({1'b0, cnt_q, 2'b00} + 8'(j)) * 8'd7;
        end
    end

    assign w_rk_idx = isdec_q ? (c_last_round - cnt_q) : cnt_q;
    assign w_rk     = rk_q[w_rk_idx];

    always_comb begin
        rf_x = '0;
        unique case (state_q)
            S_KEXP:  rf_x = k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ w_ck;
            S_RND:   rf_x = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ w_rk;
            default: rf_x = '0;
        endcase
    end

    assign w_new     = ((state_q == S_KEXP) ? k_q[127:96] : x_q[127:96]) ^ rf_t;
    assign rf_mode   = (state_q == S_KEXP);
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    // Register order after the last round is X32..X35; R reverses it
    assign dataout   = (state_q == S_DONE) ?
                       {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]} : '0;

`ifdef SM4_KEY_CACHE_EN
    logic [127:0] ckey_q, ckey_d;
    logic         cvld_q, cvld_d;

    assign w_hit = cvld_q && (mkin == ckey_q);

    // The key is captured at start; it only becomes valid once its expansion completes
    always_comb begin
        ckey_d = ckey_q;
        cvld_d = cvld_q;
        if (state_q == S_IDLE && start_input && !w_hit) begin
            ckey_d = mkin;
            cvld_d = 1'b0;
        end else if (state_q == S_KEXP && cnt_q == c_last_round) begin
            cvld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ckey_q <= '0;
            cvld_q <= 1'b0;
        end else begin
            ckey_q <= ckey_d;
            cvld_q <= cvld_d;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        isdec_d = isdec_q;
        x_d     = x_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_input) begin
                    isdec_d = isdec;
                    x_d     = datain;
                    k_d     = mkin ^ FK;
                    cnt_d   = '0;
                    state_d = w_hit ? S_RND : S_KEXP;
                end
            end
            S_KEXP: begin
                k_d   = {k_q[95:0], w_new};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == c_last_round) begin
                    cnt_d   = '0;
                    state_d = S_RND;
                end
            end
            S_RND: begin
                x_d   = {x_q[95:0], w_new};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == c_last_round) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            isdec_q <= 1'b0;
            x_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            isdec_q <= isdec_d;
            x_q     <= x_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_KEXP) begin
            rk_q[cnt_q] <= w_new;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm4_round_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sm4_round_sched                                           |
// | Description : Directed bench for sm4_round_sched with a behavioural T/T'.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_sm4_round_sched;

`ifdef SM4_KEY_CACHE_EN
    localparam int LAT_HIT = 33;
`else
    localparam int LAT_HIT = 65;
`endif
    localparam int LAT_FULL = 65;

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    localparam logic [127:0] KEY_A = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT_A  = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [127:0] KEY_B = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_input = 1'b0;
    logic         isdec = 1'b0;
    logic [127:0] datain = '0;
    logic [127:0] mkin = '0;
    logic         in_ready;
    logic         rf_mode;
    logic [31:0]  rf_x;
    logic [31:0]  rf_t;
    logic [127:0] dataout;
    logic         out_valid;
    logic         out_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    sm4_round_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start_input (start_input),
        .isdec       (isdec),
        .datain      (datain),
        .mkin        (mkin),
        .in_ready    (in_ready),
        .rf_mode     (rf_mode),
        .rf_x        (rf_x),
        .rf_t        (rf_t),
        .dataout     (dataout),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] a);
        return SBOX[2047 - 8*int'(a) -: 8];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tf(input logic [31:0] x, input logic m);
        logic [31:0] b;
        b = {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
        if (m) return b ^ rol(b, 13) ^ rol(b, 23);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    assign rf_t = tf(rf_x, rf_mode);

    typedef struct {
        logic         dec;
        logic [127:0] din;
        logic [127:0] key;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_blk(input logic d, input logic [127:0] din, input logic [127:0] key);
        isdec       = d;
        datain      = din;
        mkin        = key;
        start_input = 1'b1;
        tick();
        start_input = 1'b0;
    endtask

    // Returns the cycle (start cycle = 0) at which out_valid rises, or -1
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic accept_and_check(input string name);
        tick();
        check({name, "_in_ready_after"}, 128'(in_ready), 128'd1);
        check({name, "_out_valid_after"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [3];
        int           lat;
        logic [127:0] y;
        logic         seen;

        tbl[0] = '{1'b0, KEY_A, KEY_A, CT_A, LAT_FULL};
        tbl[1] = '{1'b1, CT_A, KEY_A, KEY_A, LAT_HIT};
        tbl[2] = '{1'b0, KEY_A, KEY_A, CT_A, LAT_HIT};

        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_dataout", dataout, 128'd0);
        check("rst_rf_mode", 128'(rf_mode), 128'd0);
        check("rst_rf_x", 128'(rf_x), 128'd0);

        for (int i = 0; i < 3; i++) begin
            start_blk(tbl[i].dec, tbl[i].din, tbl[i].key);
            check($sformatf("vec%0d_busy_in_ready", i), 128'(in_ready), 128'd0);
            wait_valid(lat);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(tbl[i].lat));
            check($sformatf("vec%0d_dataout", i), dataout, tbl[i].exp);
            accept_and_check($sformatf("vec%0d", i));
        end

        // Backpressure with ignored start pulses during the hold window
        out_ready = 1'b0;
        start_blk(1'b0, KEY_A, KEY_A);
        wait_valid(lat);
        check("bp_latency", 128'(lat), 128'(LAT_HIT));
        for (int i = 0; i < 10; i++) begin
            start_input = (i % 2 == 0);
            mkin        = KEY_B;
            datain      = '0;
            tick();
            check($sformatf("bp_dataout_%0d", i), dataout, CT_A);
            check($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'd0);
        end
        start_input = 1'b0;
        check("bp_still_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        accept_and_check("bp");
        repeat (3) tick();
        check("bp_not_queued_valid", 128'(out_valid), 128'd0);
        check("bp_not_queued_ready", 128'(in_ready), 128'd1);

        // New key forces a full expansion; decrypt round-trips the result
        start_blk(1'b0, 128'd0, KEY_B);
        wait_valid(lat);
        check("keyb_enc_latency", 128'(lat), 128'(LAT_FULL));
        y = dataout;
        accept_and_check("keyb_enc");
        start_blk(1'b1, y, KEY_B);
        wait_valid(lat);
        check("keyb_dec_latency", 128'(lat), 128'(LAT_HIT));
        check("keyb_roundtrip", dataout, 128'd0);
        accept_and_check("keyb_dec");

        // Reset asserted in cycle 20 of key expansion
        start_blk(1'b0, 128'd0, KEY_A ^ 128'd1);
        repeat (19) tick();
        check("abort_in_kexp", 128'(rf_mode), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_dataout", dataout, 128'd0);
        check("abort_rf_mode", 128'(rf_mode), 128'd0);
        start_blk(1'b0, KEY_A, KEY_A);
        wait_valid(lat);
        check("abort_fresh_latency", 128'(lat), 128'(LAT_FULL));
        check("abort_fresh_dataout", dataout, CT_A);
        accept_and_check("abort_fresh");

        // Reset in IDLE must invalidate any cached key
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_blk(1'b0, KEY_A, KEY_A);
        wait_valid(lat);
        check("post_rst_latency", 128'(lat), 128'(LAT_FULL));
        check("post_rst_dataout", dataout, CT_A);
        accept_and_check("post_rst");

        // start_input together with rst: nothing starts
        rst         = 1'b1;
        start_input = 1'b1;
        tick();
        rst         = 1'b0;
        start_input = 1'b0;
        check("simul_in_ready", 128'(in_ready), 128'd1);
        check("simul_out_valid", 128'(out_valid), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check("simul_no_activity", 128'(seen), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
